uart_transmitter: RTL and testbench

UART_TRANSMITTER -- requirements
Module: uart_transmitter

---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_baud_gen.sv | 29 ++
 rtl/uart_transmitter.sv | 125 ++++++++++++
 tb/tb_uart_transmitter.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmitter.
// Build option UART_TX_PARITY_EN adds an even-parity symbol (11-symbol frame instead of 10).
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        PARITY = 3'd3,
`endif
        STOP   = 3'd4
    } txState_t;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

`ifdef UART_TX_PARITY_EN
    localparam int FRAME_SYMBOLS = 11;
`else
    localparam int FRAME_SYMBOLS = 10;
`endif

endpackage

// File: rtl/uart_baud_gen.sv
// Symbol timer: one-cycle Tick every SymbolEdgeTime cycles, restarted to zero on Restart.
module uart_baud_gen #(
    parameter int SymbolEdgeTime = 434
) (
    input  logic Clock,
    input  logic Reset,
    input  logic Restart,
    output logic Tick
);

    localparam int CntW = (SymbolEdgeTime > 1) ? $clog2(SymbolEdgeTime) : 1;
    localparam logic [CntW-1:0] LastCount = CntW'(SymbolEdgeTime - 1);

    logic [CntW-1:0] count;

    always_ff @(posedge Clock) begin
        if (Reset || Restart) begin
            count <= '0;
        end else if (count == LastCount) begin
            count <= '0;
        end else begin
            count <= count + CntW'(1);
        end
    end

    // Tick marks the last cycle of a symbol; the FSM advances on the following edge.
    assign Tick = (count == LastCount);

endmodule

// File: rtl/uart_transmitter.sv
// UART transmitter: one-entry holding register feeding a frame shifter, 8N1 frames.
// Define UART_TX_PARITY_EN to insert an even-parity symbol between bit 7 and stop.
module uart_transmitter
    import uart_pkg::*;
#(
    parameter int ClockFreq = 50_000_000,
    parameter int BaudRate  = 115_200
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic [7:0] DataIn,
    input  logic       DataInValid,
    output logic       DataInReady,
    output logic       SOut,
    output logic       TxBusy,
    output txState_t   TxState
);

    // Handshake: a byte transfers on a rising edge where DataInValid and DataInReady
    // are both high; DataInReady depends only on registered state, never on DataInValid.

    localparam int SymbolEdgeTime = ClockFreq / BaudRate;

    txState_t   state;
    txState_t   nextState;
    logic       holdFull;
    logic [7:0] holdData;
    logic [7:0] shiftReg;
    logic [2:0] bitCnt;
    logic       tick;
    logic       accept;
    logic       loadShifter;
`ifdef UART_TX_PARITY_EN
    logic       parityBit;
`endif

    assign accept      = DataInValid && !holdFull;
    assign loadShifter = (nextState == START) && (state != START);

    uart_baud_gen #(
        .SymbolEdgeTime(SymbolEdgeTime)
    ) baudGen (
        .Clock  (Clock),
        .Reset  (Reset),
        .Restart(loadShifter),
        .Tick   (tick)
    );

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE:   if (holdFull) nextState = START;
            START:  if (tick) nextState = DATA;
            DATA: begin
                if (tick && bitCnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                    nextState = PARITY;
`else
                    nextState = STOP;
`endif
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: if (tick) nextState = STOP;
`endif
            // A queued byte starts its frame straight after the stop bit.
            STOP:   if (tick) nextState = holdFull ? START : IDLE;
            default: nextState = IDLE;
        endcase
    end

    // Load and accept never coincide: loading needs a full holding register, accepting an empty one.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            holdFull  <= 1'b0;
            holdData  <= '0;
            shiftReg  <= '0;
            bitCnt    <= '0;
`ifdef UART_TX_PARITY_EN
            parityBit <= 1'b0;
`endif
        end else if (loadShifter) begin
            shiftReg  <= holdData;
            bitCnt    <= '0;
            holdFull  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parityBit <= ^holdData;
`endif
        end else begin
            if (accept) begin
                holdFull <= 1'b1;
                holdData <= DataIn;
            end
            if (state == DATA && tick) begin
                shiftReg <= shiftReg >> 1;
                if (bitCnt != 3'd7) bitCnt <= bitCnt + 3'd1;
            end
        end
    end

    always_comb begin
        SOut = STOP_BIT;
        case (state)
            START:  SOut = START_BIT;
            DATA:   SOut = shiftReg[0];
`ifdef UART_TX_PARITY_EN
            PARITY: SOut = parityBit;
`endif
            default: SOut = STOP_BIT;
        endcase
    end

    assign DataInReady = ~holdFull;
    assign TxBusy      = (state != IDLE) || holdFull;
    assign TxState     = state;

endmodule

// File: tb/tb_uart_transmitter.sv
// Directed bench for uart_transmitter at default clock/baud (434 cycles per symbol).
// Honours UART_TX_PARITY_EN for the expected frame shape.
module tb_uart_transmitter;
    import uart_pkg::*;

    localparam int SET = 50_000_000 / 115_200;
    localparam int FW  = FRAME_SYMBOLS;

    // Frames in symbol order, bit 0 = start bit, hand-assembled for 8'h7a.
`ifdef UART_TX_PARITY_EN
    localparam logic [FW-1:0] EXP_7A = 11'b1_1_01111010_0;
`else
    localparam logic [FW-1:0] EXP_7A = 10'b1_01111010_0;
`endif

    logic       Clock = 1'b0;
    logic       Reset;
    logic [7:0] DataIn;
    logic       DataInValid;
    logic       DataInReady;
    logic       SOut;
    logic       TxBusy;
    txState_t   TxState;

    int checks   = 0;
    int failures = 0;

    uart_transmitter dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .DataIn     (DataIn),
        .DataInValid(DataInValid),
        .DataInReady(DataInReady),
        .SOut       (SOut),
        .TxBusy     (TxBusy),
        .TxState    (TxState)
    );

    always #5 Clock = ~Clock;

    function automatic logic [FW-1:0] frame_bits(input logic [7:0] d);
        logic [FW-1:0] f;
        f      = '1;
        f[0]   = 1'b0;
        f[8:1] = d;
`ifdef UART_TX_PARITY_EN
        f[9]   = ^d;
`endif
        return f;
    endfunction

    // Records one frame starting at a negedge inside (or before) the start bit; firstDone
    // is how many start-bit cycles the caller has already consumed.
    task automatic capture_frame(input int waitCycles, input int firstDone,
                                 output logic [FW-1:0] bits, output int glitches,
                                 output bit found);
        int n;
        found    = 1'b0;
        glitches = 0;
        bits     = '1;
        n        = 0;
        while (SOut !== 1'b0 && n < waitCycles) begin
            @(negedge Clock);
            n++;
        end
        if (SOut !== 1'b0) return;
        found = 1'b1;
        for (int s = 0; s < FW; s++) begin
            bits[s] = SOut;
            for (int c = ((s == 0) ? firstDone : 0); c < SET; c++) begin
                if (SOut !== bits[s]) glitches++;
                @(negedge Clock);
            end
        end
    endtask

    task automatic test_reset();
        Reset = 1'b1; DataInValid = 1'b1; DataIn = 8'hA5;
        repeat (30) @(negedge Clock);
        checks++; if (SOut !== 1'b1) begin failures++; $display("FAIL reset_sout: got %b expected 1", SOut); end
        checks++; if (DataInReady !== 1'b1) begin failures++; $display("FAIL reset_ready: got %b expected 1", DataInReady); end
        checks++; if (TxBusy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", TxBusy); end
        checks++; if (TxState !== IDLE) begin failures++; $display("FAIL reset_state: got %0d expected %0d", TxState, IDLE); end
        Reset = 1'b0; DataInValid = 1'b0;
        repeat (3) @(negedge Clock);
        checks++; if (DataInReady !== 1'b1 || TxBusy !== 1'b0 || SOut !== 1'b1)
            begin failures++; $display("FAIL reset_no_accept: ready=%b busy=%b sout=%b expected 1 0 1", DataInReady, TxBusy, SOut); end
    endtask

    task automatic test_single();
        logic [FW-1:0] bits; int gl; bit found;
        DataIn = 8'h7a; DataInValid = 1'b1;
        @(negedge Clock);
        DataInValid = 1'b0;
        checks++; if (DataInReady !== 1'b0 || TxBusy !== 1'b1 || SOut !== 1'b1)
            begin failures++; $display("FAIL single_accept: ready=%b busy=%b sout=%b expected 0 1 1", DataInReady, TxBusy, SOut); end
        @(negedge Clock);
        checks++; if (SOut !== 1'b0 || DataInReady !== 1'b1 || TxState !== START)
            begin failures++; $display("FAIL single_latency: sout=%b ready=%b state=%0d expected 0 1 %0d", SOut, DataInReady, TxState, START); end
        capture_frame(0, 0, bits, gl, found);
        checks++; if (!found) begin failures++; $display("FAIL single_found: no start bit, expected one"); end
        checks++; if (bits !== EXP_7A) begin failures++; $display("FAIL single_bits: got %b expected %b", bits, EXP_7A); end
        checks++; if (gl !== 0) begin failures++; $display("FAIL single_timing: got %0d off-level cycles expected 0", gl); end
        checks++; if (TxBusy !== 1'b0 || SOut !== 1'b1 || TxState !== IDLE)
            begin failures++; $display("FAIL single_end: busy=%b sout=%b state=%0d expected 0 1 %0d", TxBusy, SOut, TxState, IDLE); end
    endtask

    task automatic test_patterns();
        logic [FW-1:0] bits; int gl; bit found;
        logic [7:0] pats [2];
        pats[0] = 8'h00; pats[1] = 8'hFF;
        for (int i = 0; i < 2; i++) begin
            DataIn = pats[i]; DataInValid = 1'b1;
            @(negedge Clock);
            DataInValid = 1'b0;
            capture_frame(4, 0, bits, gl, found);
            checks++; if (!found || bits !== frame_bits(pats[i]) || gl !== 0)
                begin failures++; $display("FAIL pattern_%h: found=%b bits=%b glitches=%0d expected 1 %b 0", pats[i], found, bits, gl, frame_bits(pats[i])); end
            checks++; if (TxBusy !== 1'b0) begin failures++; $display("FAIL pattern_%h_idle: busy=%b expected 0", pats[i], TxBusy); end
        end
    endtask

    task automatic test_back_to_back();
        logic [FW-1:0] bits; int gl; bit found;
        DataIn = 8'h55; DataInValid = 1'b1;
        @(negedge Clock);
        checks++; if (DataInReady !== 1'b0) begin failures++; $display("FAIL b2b_ready_after_first: got %b expected 0", DataInReady); end
        DataIn = 8'hAA;
        @(negedge Clock);
        checks++; if (SOut !== 1'b0 || DataInReady !== 1'b1)
            begin failures++; $display("FAIL b2b_first_start: sout=%b ready=%b expected 0 1", SOut, DataInReady); end
        @(negedge Clock);
        DataInValid = 1'b0;
        checks++; if (DataInReady !== 1'b0 || TxBusy !== 1'b1)
            begin failures++; $display("FAIL b2b_both_pending: ready=%b busy=%b expected 0 1", DataInReady, TxBusy); end
        capture_frame(0, 1, bits, gl, found);
        checks++; if (!found || bits !== frame_bits(8'h55) || gl !== 0)
            begin failures++; $display("FAIL b2b_frame55: found=%b bits=%b glitches=%0d expected 1 %b 0", found, bits, gl, frame_bits(8'h55)); end
        checks++; if (SOut !== 1'b0 || DataInReady !== 1'b1)
            begin failures++; $display("FAIL b2b_no_gap: sout=%b ready=%b expected 0 1", SOut, DataInReady); end
        capture_frame(0, 0, bits, gl, found);
        checks++; if (!found || bits !== frame_bits(8'hAA) || gl !== 0)
            begin failures++; $display("FAIL b2b_frameAA: found=%b bits=%b glitches=%0d expected 1 %b 0", found, bits, gl, frame_bits(8'hAA)); end
        checks++; if (TxBusy !== 1'b0 || TxState !== IDLE)
            begin failures++; $display("FAIL b2b_end: busy=%b state=%0d expected 0 %0d", TxBusy, TxState, IDLE); end
    endtask

    task automatic test_drop();
        logic [FW-1:0] bits; int gl; bit found; int lowCycles;
        DataIn = 8'h3C; DataInValid = 1'b1;
        @(negedge Clock);
        DataIn = 8'hC5;
        @(negedge Clock);
        @(negedge Clock);
        DataInValid = 1'b0;
        repeat (100) @(negedge Clock);
        checks++; if (DataInReady !== 1'b0) begin failures++; $display("FAIL drop_ready_low: got %b expected 0", DataInReady); end
        DataIn = 8'h12; DataInValid = 1'b1;
        @(negedge Clock);
        DataInValid = 1'b0; DataIn = 8'h00;
        checks++; if (DataInReady !== 1'b0) begin failures++; $display("FAIL drop_still_full: got %b expected 0", DataInReady); end
        capture_frame(0, 102, bits, gl, found);
        checks++; if (!found || bits !== frame_bits(8'h3C) || gl !== 0)
            begin failures++; $display("FAIL drop_frame3C: found=%b bits=%b glitches=%0d expected 1 %b 0", found, bits, gl, frame_bits(8'h3C)); end
        capture_frame(0, 0, bits, gl, found);
        checks++; if (!found || bits !== frame_bits(8'hC5) || gl !== 0)
            begin failures++; $display("FAIL drop_frameC5: found=%b bits=%b glitches=%0d expected 1 %b 0", found, bits, gl, frame_bits(8'hC5)); end
        lowCycles = 0;
        repeat (2 * SET) begin
            if (SOut !== 1'b1) lowCycles++;
            @(negedge Clock);
        end
        checks++; if (lowCycles !== 0 || TxBusy !== 1'b0)
            begin failures++; $display("FAIL drop_no_third: low=%0d busy=%b expected 0 0", lowCycles, TxBusy); end
    endtask

    task automatic test_reset_midframe();
        int lowCycles;
        DataIn = 8'hFF; DataInValid = 1'b1;
        @(negedge Clock);
        DataIn = 8'h00;
        @(negedge Clock);
        @(negedge Clock);
        DataInValid = 1'b0;
        repeat (4 * SET + SET / 2 - 2) @(negedge Clock);
        checks++; if (TxState !== DATA || SOut !== 1'b1 || DataInReady !== 1'b0)
            begin failures++; $display("FAIL midframe_pre: state=%0d sout=%b ready=%b expected %0d 1 0", TxState, SOut, DataInReady, DATA); end
        Reset = 1'b1;
        @(negedge Clock);
        checks++; if (SOut !== 1'b1 || DataInReady !== 1'b1 || TxBusy !== 1'b0 || TxState !== IDLE)
            begin failures++; $display("FAIL midframe_reset: sout=%b ready=%b busy=%b state=%0d expected 1 1 0 %0d", SOut, DataInReady, TxBusy, TxState, IDLE); end
        Reset = 1'b0;
        lowCycles = 0;
        repeat (12 * SET) begin
            @(negedge Clock);
            if (SOut !== 1'b1) lowCycles++;
        end
        checks++; if (lowCycles !== 0 || TxBusy !== 1'b0)
            begin failures++; $display("FAIL midframe_discard: low=%0d busy=%b expected 0 0", lowCycles, TxBusy); end
    endtask

    initial begin
        Reset = 1'b1; DataInValid = 1'b0; DataIn = 8'h00;
        test_reset();
        test_single();
        test_patterns();
        test_back_to_back();
        test_drop();
        test_reset_midframe();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
